// File: rtl/i2c_slave_byte_ctrl_if.sv
// i2c_slave_byte_ctrl_if: pad-side I2C lines plus user-side rx/tx byte handshake for the I2C target
interface i2c_slave_byte_ctrl_if;
  logic       ena;
  logic       ack_en;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       scl_oen;
  logic       sda_oen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_valid;
  logic       rd_mode;
  logic       addressed;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  modport slave (
    input  ena, ack_en, scl_i, sda_i, tx_data, tx_valid,
    output scl_o, sda_o, scl_oen, sda_oen, rx_data, rx_valid, tx_req, rd_mode, addressed, busy, start_det, stop_det
  );
  modport master (
    output ena, ack_en, scl_i, sda_i, tx_data, tx_valid,
    input  scl_o, sda_o, scl_oen, sda_oen, rx_data, rx_valid, tx_req, rd_mode, addressed, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl: byte-level I2C target with input filtering, address match, rx delivery and stretched tx
module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input logic            clk,
  input logic            nReset,
  i2c_slave_byte_ctrl_if.slave bus
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, IGNORE, RX, RX_ACK, TX_WAIT, TX, TX_ACK} state_t;
  logic [1:0]      s0, s1, f, p;
  logic [1:0][3:0] fc;
  logic            scl_f, sda_f, scl_rise, scl_fall, start, stop;
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [6:0]      sr;
  logic            ph;
  logic            scl_oen, sda_oen, rx_valid, tx_req, rd_mode, addressed, busy, start_det, stop_det;
  logic [7:0]      rx_data;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      s0 <= '1;
      s1 <= '1;
      f  <= '1;
      p  <= '1;
      fc <= '0;
    end else begin
      s0 <= {bus.sda_i, bus.scl_i};
      s1 <= s0;
      p  <= f;
      for (int i = 0; i < 2; i++)
        if (s1[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == 4'(FILT_LEN - 1)) begin
          f[i]  <= s1[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 4'd1;
    end
  assign scl_f    = f[0];
  assign sda_f    = f[1];
  assign scl_rise = scl_f & ~p[0];
  assign scl_fall = ~scl_f & p[0];
  assign start    = scl_f & p[0] & ~sda_f & p[1];
  assign stop     = scl_f & p[0] & sda_f & ~p[1];
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      ph        <= 1'b0;
      scl_oen   <= 1'b1;
      sda_oen   <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rd_mode   <= 1'b0;
      addressed <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (!bus.ena) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ph        <= 1'b0;
        scl_oen   <= 1'b1;
        sda_oen   <= 1'b1;
        tx_req    <= 1'b0;
        rd_mode   <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b0;
      end else if (start || stop) begin
        state     <= start ? ADDR : IDLE;
        bit_cnt   <= '0;
        ph        <= 1'b0;
        scl_oen   <= 1'b1;
        sda_oen   <= 1'b1;
        tx_req    <= 1'b0;
        addressed <= 1'b0;
        busy      <= start;
        start_det <= start;
        stop_det  <= stop;
      end else case (state)
        ADDR: if (scl_rise) begin
          sr      <= {sr[5:0], sda_f};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (sr == SLAVE_ADDR) begin
              rd_mode   <= sda_f;
              addressed <= 1'b1;
              state     <= ADDR_ACK;
            end else state <= IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          ph      <= !ph;
          sda_oen <= ph;
          if (ph) begin
            state   <= rd_mode ? TX_WAIT : RX;
            scl_oen <= !rd_mode;
            tx_req  <= rd_mode;
          end
        end
        RX: if (scl_rise) begin
          sr      <= {sr[5:0], sda_f};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data  <= {sr, sda_f};
            rx_valid <= 1'b1;
            state    <= RX_ACK;
          end
        end
        RX_ACK: if (scl_fall) begin
          ph      <= !ph;
          sda_oen <= ph | !bus.ack_en;
          if (ph) begin
            state   <= RX;
            bit_cnt <= '0;
          end
        end
        TX_WAIT: if (tx_req && bus.tx_valid) begin
          sr      <= bus.tx_data[6:0];
          sda_oen <= bus.tx_data[7];
          tx_req  <= 1'b0;
          bit_cnt <= '0;
          state   <= TX;
        end
        TX: begin
          scl_oen <= 1'b1;
          if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            sr      <= {sr[5:0], 1'b0};
            sda_oen <= bit_cnt == 3'd7 ? 1'b1 : sr[6];
            if (bit_cnt == 3'd7) state <= TX_ACK;
          end
        end
        TX_ACK: if (scl_rise) begin
          if (sda_f) begin
            addressed <= 1'b0;
            state     <= IGNORE;
          end else ph <= 1'b1;
        end else if (scl_fall && ph) begin
          ph      <= 1'b0;
          state   <= TX_WAIT;
          scl_oen <= 1'b0;
          tx_req  <= 1'b1;
        end
        default: ;
      endcase
    end
  assign bus.scl_o     = 1'b0;
  assign bus.sda_o     = 1'b0;
  assign bus.scl_oen   = scl_oen;
  assign bus.sda_oen   = sda_oen;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.tx_req    = tx_req;
  assign bus.rd_mode   = rd_mode;
  assign bus.addressed = addressed;
  assign bus.busy      = busy;
  assign bus.start_det = start_det;
  assign bus.stop_det  = stop_det;
endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// tb_i2c_slave_byte_ctrl: directed bus-master stimulus with immediate-assertion checks for the I2C target
module tb_i2c_slave_byte_ctrl;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic samp;
  logic ack;
  logic held;
  logic [7:0] rb;
  int n_assert = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  i2c_slave_byte_ctrl_if bif ();
  i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (.clk(clk), .nReset(nReset), .bus(bif.slave));
  assign bif.scl_i = m_scl & (bif.scl_oen | bif.scl_o);
  assign bif.sda_i = m_sda & (bif.sda_oen | bif.sda_o);
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bif.rx_valid) begin
      rx_cnt++;
      rx_last = bif.rx_data;
    end
    if (bif.start_det) start_cnt++;
    if (bif.stop_det) stop_cnt++;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scl_high();
    m_scl = 1'b1;
    wait_cyc(1);
    for (int i = 0; i < 200 && !bif.scl_i; i++) wait_cyc(1);
    chk("scl_high", 32'(bif.scl_i), 1);
  endtask
  task automatic clk_bit(input logic b);
    m_sda = b;
    wait_cyc(10);
    scl_high();
    wait_cyc(10);
    samp = bif.sda_i;
    wait_cyc(10);
    m_scl = 1'b0;
    wait_cyc(10);
  endtask
  task automatic i2c_start();
    m_sda = 1'b1;
    wait_cyc(10);
    scl_high();
    wait_cyc(10);
    m_sda = 1'b0;
    wait_cyc(5);
    chk("start_det_early", 32'(bif.start_det), 0);
    wait_cyc(1);
    chk("start_det_latency", 32'(bif.start_det), 1);
    wait_cyc(14);
    m_scl = 1'b0;
    wait_cyc(10);
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_cyc(10);
    scl_high();
    wait_cyc(10);
    m_sda = 1'b1;
    wait_cyc(20);
  endtask
  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) clk_bit(d[i]);
    clk_bit(1'b1);
    a = samp;
  endtask
  task automatic read_byte(output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1);
      d = {d[6:0], samp};
    end
  endtask
  task automatic provide(input logic [7:0] d, input int dly, output logic h);
    h = 1'b1;
    for (int i = 0; i < 200 && !bif.tx_req; i++) wait_cyc(1);
    chk("tx_req_asserted", 32'(bif.tx_req), 1);
    for (int i = 0; i < dly; i++) begin
      h = h & ~bif.scl_i & bif.tx_req;
      wait_cyc(1);
    end
    bif.tx_data  = d;
    bif.tx_valid = 1'b1;
    wait_cyc(1);
    chk("hs_sda_msb", 32'(bif.sda_oen), 32'(d[7]));
    chk("hs_scl_still_held", 32'(bif.scl_oen), 0);
    chk("hs_tx_req_drop", 32'(bif.tx_req), 0);
    bif.tx_valid = 1'b0;
    wait_cyc(1);
    chk("scl_release_after_hs", 32'(bif.scl_oen), 1);
  endtask
  initial begin
    bif.ena      = 1'b1;
    bif.ack_en   = 1'b1;
    bif.tx_data  = 8'h00;
    bif.tx_valid = 1'b0;
    wait_cyc(3);
    nReset = 1'b1;
    wait_cyc(2);
    chk("reset_flags", 32'({bif.scl_oen, bif.sda_oen, bif.scl_o, bif.sda_o, bif.rx_valid, bif.tx_req,
                            bif.rd_mode, bif.addressed, bif.busy, bif.start_det, bif.stop_det}), 32'h600);
    chk("reset_rx_data", 32'(bif.rx_data), 0);
    i2c_start();
    chk("w_start_cnt", start_cnt, 1);
    chk("w_busy", 32'(bif.busy), 1);
    write_byte(8'hA0, ack);
    chk("w_addr_ack", 32'(ack), 0);
    chk("w_addressed", 32'(bif.addressed), 1);
    chk("w_rd_mode", 32'(bif.rd_mode), 0);
    write_byte(8'h3C, ack);
    chk("w_d0_ack", 32'(ack), 0);
    chk("w_d0_cnt", rx_cnt, 1);
    chk("w_d0_data", 32'(rx_last), 32'h3C);
    write_byte(8'hC3, ack);
    chk("w_d1_ack", 32'(ack), 0);
    chk("w_d1_cnt", rx_cnt, 2);
    chk("w_d1_data", 32'(rx_last), 32'hC3);
    i2c_stop();
    chk("w_stop_cnt", stop_cnt, 1);
    chk("w_stop_addressed", 32'(bif.addressed), 0);
    chk("w_stop_busy", 32'(bif.busy), 0);
    i2c_start();
    write_byte(8'hA2, ack);
    chk("nm_addr_nack", 32'(ack), 1);
    chk("nm_addressed", 32'(bif.addressed), 0);
    chk("nm_busy", 32'(bif.busy), 1);
    write_byte(8'h11, ack);
    chk("nm_data_nack", 32'(ack), 1);
    chk("nm_no_rx", rx_cnt, 2);
    chk("nm_busy_hold", 32'(bif.busy), 1);
    i2c_stop();
    chk("nm_stop_busy", 32'(bif.busy), 0);
    chk("nm_stop_cnt", stop_cnt, 2);
    i2c_start();
    write_byte(8'hA1, ack);
    chk("r_addr_ack", 32'(ack), 0);
    chk("r_rd_mode", 32'(bif.rd_mode), 1);
    fork
      read_byte(rb);
      provide(8'h96, 20, held);
    join
    chk("r_b0_data", 32'(rb), 32'h96);
    chk("r_b0_stretch", 32'(held), 1);
    clk_bit(1'b0);
    chk("r_ack_tx_req", 32'(bif.tx_req), 1);
    chk("r_ack_stretch", 32'(bif.scl_oen), 0);
    fork
      read_byte(rb);
      provide(8'h5A, 3, held);
    join
    chk("r_b1_data", 32'(rb), 32'h5A);
    chk("r_b1_stretch", 32'(held), 1);
    clk_bit(1'b1);
    chk("r_nack_addressed", 32'(bif.addressed), 0);
    chk("r_nack_sda_rel", 32'(bif.sda_oen), 1);
    chk("r_nack_tx_req", 32'(bif.tx_req), 0);
    i2c_stop();
    chk("r_stop_cnt", stop_cnt, 3);
    i2c_start();
    write_byte(8'hA0, ack);
    chk("na_addr_ack", 32'(ack), 0);
    bif.ack_en = 1'b0;
    write_byte(8'h55, ack);
    chk("na_data_nack", 32'(ack), 1);
    chk("na_rx_cnt", rx_cnt, 3);
    chk("na_rx_data", 32'(rx_last), 32'h55);
    bif.ack_en = 1'b1;
    i2c_start();
    chk("rs_start_cnt", start_cnt, 5);
    chk("rs_busy", 32'(bif.busy), 1);
    write_byte(8'hA1, ack);
    chk("rs_addr_ack", 32'(ack), 0);
    chk("rs_rd_mode", 32'(bif.rd_mode), 1);
    chk("rs_tx_req", 32'(bif.tx_req), 1);
    chk("rs_stretch", 32'(bif.scl_oen), 0);
    bif.ena = 1'b0;
    wait_cyc(1);
    chk("ena_off_flags", 32'({bif.scl_oen, bif.sda_oen, bif.tx_req, bif.addressed, bif.busy, bif.rd_mode}), 32'h30);
    chk("ena_off_rx_data", 32'(bif.rx_data), 32'h55);
    bif.ena = 1'b1;
    i2c_stop();
    chk("ena_stop_cnt", stop_cnt, 4);
    i2c_start();
    clk_bit(1'b1);
    clk_bit(1'b0);
    m_sda = 1'b1;
    wait_cyc(10);
    scl_high();
    wait_cyc(10);
    m_sda = 1'b0;
    wait_cyc(2);
    m_sda = 1'b1;
    wait_cyc(15);
    chk("glitch_no_start", start_cnt, 6);
    chk("glitch_no_stop", stop_cnt, 4);
    chk("glitch_busy", 32'(bif.busy), 1);
    nReset = 1'b0;
    #1;
    chk("arst_release", 32'({bif.scl_oen, bif.sda_oen, bif.busy}), 32'h6);
    wait_cyc(2);
    nReset = 1'b1;
    wait_cyc(1);
    chk("arst_flags", 32'({bif.scl_oen, bif.sda_oen, bif.scl_o, bif.sda_o, bif.rx_valid, bif.tx_req,
                           bif.rd_mode, bif.addressed, bif.busy, bif.start_det, bif.stop_det}), 32'h600);
    chk("arst_rx_data", 32'(bif.rx_data), 0);
    m_scl = 1'b0;
    wait_cyc(10);
    i2c_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_byte_ctrl.md
# i2c_slave_byte_ctrl

Byte-level I2C target (slave) controller: the responder end of the bus driven by the team's I2C master byte/bit controllers. It filters SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs and delivers received bytes to the user side, and serves read transactions from a user-supplied byte stream. During reads it stretches SCL while it waits for data. It sits between the open-drain pad buffers and a register-file or FIFO front end.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit address this target answers.
- FILT_LEN, 3: number of consecutive equal synchronized samples (1..15) before the filtered SCL/SDA change.
- clk  in  1  master clock; all logic on posedge.
- nReset  in  1  reset, asynchronous active-low.
- ena  in  1  core enable; 0 forces IDLE and releases both lines.
- ack_en  in  1  1: ACK received data bytes; 0: NACK them. The address is always ACKed on match.
- scl_i / sda_i  in  1  pad inputs.
- scl_o / sda_o  out  1  constant 0 (open-drain).
- scl_oen / sda_oen  out  1  output enable, active-low; 1 = released.
- rx_data  out  8  last received data byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  8  byte to send on a read.
- tx_req  out  1  level; the target needs a byte.
- tx_valid  in  1  the byte is accepted in the cycle where tx_req & tx_valid.
- rd_mode  out  1  R/W bit of the current addressed transaction.
- addressed  out  1  high from the address ACK until STOP, repeated START or NACK-ended read.
- busy  out  1  high between a detected START and STOP.
- start_det / stop_det  out  1  one-cycle pulses.

## Operation
- Input path: 2-flop synchronizer, then a glitch filter (FILT_LEN equal samples) producing scl_f/sda_f; edge detect on the filtered signals.
- START: sda_f falls while scl_f = 1. STOP: sda_f rises while scl_f = 1. Either one has priority over all states, resets the bit counter and releases SDA/SCL. START goes to ADDR; STOP goes to IDLE. A START while busy is a repeated START, and start_det pulses.
- Data sampling is on scl_f rising. The target changes SDA only on scl_f falling.
- States: IDLE, ADDR, ADDR_ACK, IGNORE, RX, RX_ACK, TX_WAIT, TX, TX_ACK.
- ADDR: shifts 8 bits. After the 8th rising edge:
  - If bits[7:1] == SLAVE_ADDR: latch rd_mode = bit0, go to ADDR_ACK.
  - Otherwise go to IGNORE, which waits for START/STOP.
- ADDR_ACK: on the next falling edge, sda_oen = 0. On the following falling edge:
  - rd_mode = 0: release SDA, go to RX.
  - rd_mode = 1: go to TX_WAIT.
  - addressed rises when entering ADDR_ACK.
- RX: 3-bit counter, MSB first. On the 8th rising edge, rx_data updates and rx_valid pulses the next cycle, then go to RX_ACK. On the next falling edge drive sda_oen = !ack_en. On the following falling edge release SDA and return to RX with the counter cleared.
- TX_WAIT: scl_oen = 0 (stretch) and tx_req = 1. On handshake:
  - load the shift register, drive sda_oen = tx_data[7];
  - release SCL the cycle after;
  - go to TX.
- TX: on each scl_f falling edge shift out the next bit (sda_oen = bit, so 1 = released). After the 8th bit's falling edge, release SDA and go to TX_ACK.
- TX_ACK: sample sda_f on the rising edge.
  - 0 (ACK): go to TX_WAIT on the next falling edge.
  - 1 (NACK): addressed drops and the FSM goes to IGNORE.
- rx_data holds its value until the next byte completes. No rx back-pressure; the user must accept a pulse within 8 SCL periods.

## Timing
- Reset values: scl_oen = 1, sda_oen = 1, scl_o = sda_o = 0, rx_data = 8'h00, rx_valid = 0, tx_req = 0, rd_mode = 0, addressed = 0, busy = 0, start_det = stop_det = 0, state IDLE.
- Pin-to-filtered latency: 2 + FILT_LEN clk cycles. All state transitions happen one cycle after the filtered edge.
- The SDA change after a falling edge gives a data hold of ≥ 3 + FILT_LEN clk, by construction.
- ena deassertion mid-transfer: next cycle IDLE, lines released, outputs hold their reset values except rx_data.
- Stretch exit: SCL is released exactly 1 cycle after the tx handshake. SDA is valid at least 1 cycle before the release.
- Simultaneous START/STOP detect and a data edge in the same cycle: START/STOP wins.
- Async reset mid-transfer: immediate release of both lines.

## Test plan
- Write to 0x50 (byte 0xA0 on the bus), then 0x3C, 0xC3, STOP → address ACK. rx_valid pulses twice with 0x3C then 0xC3, each byte ACKed. stop_det pulses, addressed = 0.
- Address 0x51 write → no ACK (SDA released on the 9th clock), state IGNORE, no rx_valid, busy = 1 until STOP.
- Read from 0x50 (0xA1 on the bus), tx_valid delayed 20 cycles → SCL held low for those 20 cycles, tx_req high throughout. Byte 0x96 appears MSB-first. Master ACK → tx_req again. Master NACK → SDA released, addressed = 0.
- ack_en = 0 during a write of 0x55 → rx_valid with 0x55, SDA released in the ACK slot.
- Repeated START after a write byte, then 0xA1 → start_det pulse, rd_mode = 1, tx_req asserted.
- SDA glitch of FILT_LEN-1 cycles while SCL is high, plus nReset pulsed mid-byte → no START/STOP detected. After the reset pulse, all outputs take their reset values.
